// File: rtl/emc_capture_slave.sv
// EMC async-SRAM bus responder: register file plus pixel FIFO read window.
// Optional THRESH register and FIFO_IRQ enabled by defining EMC_CAPTURE_SLAVE_IRQ_EN.
module emc_capture_slave #(
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned FIFO_DEPTH = 512,
    parameter logic [15:0] ID_VALUE   = 16'h5E5E
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              EMC_CS_N,
    input  logic              EMC_OEN_N,
    input  logic              EMC_RW_N,
    input  logic [ADDR_W-1:0] EMC_AB,
    input  logic [1:0]        EMC_BYTEN,
    input  logic [15:0]       EMC_DB_I,
    output logic [15:0]       EMC_DB_O,
    output logic              EMC_DB_OE,
    input  logic              PIX_VALID,
    input  logic [15:0]       PIX_DATA,
    output logic              CAPTURE_EN,
    output logic              FIFO_IRQ
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    localparam logic [ADDR_W-1:0] A_ID      = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] A_CTRL    = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] A_STATUS  = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] A_PIXEL   = ADDR_W'(3);
    localparam logic [ADDR_W-1:0] A_SCRATCH = ADDR_W'(4);
`ifdef EMC_CAPTURE_SLAVE_IRQ_EN
    localparam logic [ADDR_W-1:0] A_THRESH  = ADDR_W'(5);
`endif

    typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_WRITE, ST_HOLD} state_t;

    state_t state, state_nxt;

    logic cs_m, oe_m, rw_m;
    logic cs_s, oe_s, rw_s;
    logic armed;

    logic [15:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [LVL_W-1:0] level;
    logic ovf, udf, flush_q;
    logic [15:0] scratch;
`ifdef EMC_CAPTURE_SLAVE_IRQ_EN
    logic [LVL_W-1:0] thresh;
`endif

    logic start_rd_c, wr_c, full_c, empty_c, pop_c, push_req_c, push_c;
    logic ovf_set_c, udf_set_c, ovf_clr_c, udf_clr_c;
    logic [15:0] rd_data_c, wr_merge_c;

    function automatic logic [15:0] merge(input logic [15:0] old_v, input logic [15:0] new_v,
                                          input logic [1:0] be_n);
        merge = {be_n[1] ? old_v[15:8] : new_v[15:8], be_n[0] ? old_v[7:0] : new_v[7:0]};
    endfunction

    // Bus strobes are asynchronous; synchronisers carry no reset so a held CS survives RESET_N.
    always_ff @(posedge CLK) begin
        cs_m <= EMC_CS_N;  cs_s <= cs_m;
        oe_m <= EMC_OEN_N; oe_s <= oe_m;
        rw_m <= EMC_RW_N;  rw_s <= rw_m;
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    // armed guarantees one access per CS assertion and blocks half-transactions after reset.
    always_comb begin
        state_nxt  = state;
        start_rd_c = 1'b0;
        case (state)
            ST_IDLE: begin
                if (armed && !cs_s) begin
                    if (rw_s && !oe_s) begin
                        state_nxt  = ST_READ;
                        start_rd_c = 1'b1;
                    end else if (!rw_s) begin
                        state_nxt = ST_WRITE;
                    end
                end
            end
            ST_READ:  if (cs_s || oe_s) state_nxt = ST_IDLE;
            ST_WRITE: state_nxt = ST_HOLD;
            ST_HOLD:  if (cs_s) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N)                                        armed <= 1'b0;
        else if (cs_s)                                       armed <= 1'b1;
        else if (state == ST_IDLE && state_nxt != ST_IDLE)   armed <= 1'b0;
    end

    assign full_c     = (level == LVL_W'(FIFO_DEPTH));
    assign empty_c    = (level == '0);
    assign wr_c       = (state == ST_WRITE);
    assign pop_c      = start_rd_c && (EMC_AB == A_PIXEL) && !empty_c;
    assign udf_set_c  = start_rd_c && (EMC_AB == A_PIXEL) && empty_c;
    assign push_req_c = PIX_VALID && CAPTURE_EN;
    assign push_c     = push_req_c && (!full_c || pop_c);
    assign ovf_set_c  = push_req_c && full_c && !pop_c;
    assign ovf_clr_c  = wr_c && (EMC_AB == A_STATUS) && !EMC_BYTEN[1] && EMC_DB_I[15];
    assign udf_clr_c  = wr_c && (EMC_AB == A_STATUS) && !EMC_BYTEN[1] && EMC_DB_I[14];

    always_comb begin
        rd_data_c  = 16'h0000;
        wr_merge_c = merge(scratch, EMC_DB_I, EMC_BYTEN);
        case (EMC_AB)
            A_ID:      rd_data_c = ID_VALUE;
            A_CTRL:    rd_data_c = {15'h0000, CAPTURE_EN};
            A_STATUS:  rd_data_c = {ovf, udf, 14'(level)};
            A_PIXEL:   rd_data_c = empty_c ? 16'h0000 : mem[rd_ptr];
            A_SCRATCH: rd_data_c = scratch;
`ifdef EMC_CAPTURE_SLAVE_IRQ_EN
            A_THRESH: begin
                rd_data_c  = 16'(thresh);
                wr_merge_c = merge(16'(thresh), EMC_DB_I, EMC_BYTEN);
            end
`endif
            default:   rd_data_c = 16'h0000;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            EMC_DB_O  <= 16'h0000;
            EMC_DB_OE <= 1'b0;
        end else if (start_rd_c) begin
            EMC_DB_O  <= rd_data_c;
            EMC_DB_OE <= 1'b1;
        end else if (state == ST_READ && state_nxt == ST_IDLE) begin
            EMC_DB_OE <= 1'b0;
        end
    end

    // Register writes commit on the single WRITE cycle.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            CAPTURE_EN <= 1'b0;
            flush_q    <= 1'b0;
            scratch    <= 16'h0000;
            ovf        <= 1'b0;
            udf        <= 1'b0;
`ifdef EMC_CAPTURE_SLAVE_IRQ_EN
            thresh     <= '0;
`endif
        end else begin
            flush_q <= 1'b0;
            if (wr_c && EMC_AB == A_CTRL && !EMC_BYTEN[0]) begin
                CAPTURE_EN <= EMC_DB_I[0];
                flush_q    <= EMC_DB_I[1];
            end
            if (wr_c && EMC_AB == A_SCRATCH) scratch <= wr_merge_c;
`ifdef EMC_CAPTURE_SLAVE_IRQ_EN
            if (wr_c && EMC_AB == A_THRESH)  thresh <= LVL_W'(wr_merge_c);
`endif
            ovf <= ovf_set_c | (ovf & ~ovf_clr_c);
            udf <= udf_set_c | (udf & ~udf_clr_c);
        end
    end

    always_ff @(posedge CLK) begin
        if (push_c && !flush_q) mem[wr_ptr] <= PIX_DATA;
    end

    // Flush overrides any same-cycle push or pop.
    always_ff @(posedge CLK) begin
        if (!RESET_N || flush_q) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_c, pop_c})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

`ifdef EMC_CAPTURE_SLAVE_IRQ_EN
    always_ff @(posedge CLK) begin
        if (!RESET_N) FIFO_IRQ <= 1'b0;
        else          FIFO_IRQ <= (level >= thresh) && (thresh != '0);
    end
`else
    assign FIFO_IRQ = 1'b0;
`endif

endmodule
